// File: rtl/fdivider_prog_pkg.sv
// fdivider_prog_pkg
// Shared constants and the duty-cycle formula for the programmable divider.
// Both the RTL and the bench reference use these so that the high-phase
// definition lives in exactly one place.
//   MIN_DIV     smallest legal divisor; 0 and 1 are rejected
//   high_phase  cycles clk_out is high per period, floor(N/2)
//   rise_point  phase at which clk_out goes high, N - floor(N/2)
package fdivider_prog_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned high_phase(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned rise_point(input int unsigned n);
        return n - high_phase(n);
    endfunction

endpackage

// File: rtl/fdivider_prog_if.sv
// fdivider_prog_if
// Control and status bundle of the programmable clock divider.
//   enable, restart, div_load, div_value : controller -> divider
//   clk_out, tick, count, div_active,
//   load_err                             : divider -> controller
// master: the controlling side; slave: the divider itself.
interface fdivider_prog_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             restart;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_active;
    logic             load_err;

    modport master (
        output enable, restart, div_load, div_value,
        input  clk_out, tick, count, div_active, load_err
    );

    modport slave (
        input  enable, restart, div_load, div_value,
        output clk_out, tick, count, div_active, load_err
    );
endinterface

// File: rtl/fdivider_prog.sv
// fdivider_prog
// Divides clk_in by a run-time programmable divisor N (div_active).
// Ports:
//   clk_in   system clock, rising edge
//   reset    synchronous, active-high
//   bus      fdivider_prog_if.slave: enable/restart/div_load/div_value in;
//            clk_out (low phase first), tick (one per period), count
//            (phase 0..N-1), div_active, load_err out
// A legal divisor is parked in a pending register and only takes effect at
// a period wrap, on restart, or while the counter is frozen, so clk_out
// never produces a runt pulse.
module fdivider_prog
    import fdivider_prog_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 100
) (
    input  logic           clk_in,
    input  logic           reset,
    fdivider_prog_if.slave bus
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] div_q, div_nxt;
    logic [WIDTH-1:0] pend_q, pend_nxt;
    logic             pend_v_q, pend_v_nxt;
    logic             clk_q, clk_nxt;
    logic             tick_q, tick_nxt;
    logic             err_q, err_nxt;
    logic             load_ok;
    logic             apply;

    always_comb begin
        load_ok    = bus.div_load && (32'(bus.div_value) >= MIN_DIV);
        err_nxt    = bus.div_load && !load_ok;
        // A same-cycle legal load overrides whatever was pending (last wins).
        pend_nxt   = load_ok ? bus.div_value : pend_q;
        pend_v_nxt = load_ok | pend_v_q;
        count_nxt  = count_q;
        div_nxt    = div_q;
        tick_nxt   = 1'b0;
        apply      = 1'b0;

        if (bus.restart) begin
            count_nxt = '0;
            apply     = 1'b1;
        end else if (!bus.enable) begin
            apply = 1'b1;
        end else if (count_q == div_q - WIDTH'(1)) begin
            count_nxt = '0;
            tick_nxt  = 1'b1;
            apply     = 1'b1;
        end else begin
            count_nxt = count_q + WIDTH'(1);
        end

        if (apply && pend_v_nxt) begin
            div_nxt    = pend_nxt;
            pend_v_nxt = 1'b0;
        end

        // Only reachable when a smaller divisor lands on a frozen counter.
        if (count_nxt >= div_nxt) begin
            count_nxt = '0;
        end

        // Derived from next count/divisor so the duty invariant holds even
        // across a divisor change on a frozen counter.
        clk_nxt = (32'(count_nxt) >= rise_point(32'(div_nxt)));
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q  <= '0;
            div_q    <= DEF_DIV;
            pend_q   <= DEF_DIV;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            div_q    <= div_nxt;
            pend_q   <= pend_nxt;
            pend_v_q <= pend_v_nxt;
            clk_q    <= clk_nxt;
            tick_q   <= tick_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.count      = count_q;
    assign bus.div_active = div_q;
    assign bus.clk_out    = clk_q;
    assign bus.tick       = tick_q;
    assign bus.load_err   = err_q;

endmodule

// File: tb/tb_fdivider_prog.sv
// tb_fdivider_prog
// Directed bench for fdivider_prog (WIDTH=8, DEFAULT_DIV=100). Stimulus
// pushes hand-computed expectations (state snapshots, tick edges, load_err
// edges) keyed by rising-edge number; a monitor on the falling edge pops and
// compares them as the DUT presents its outputs.
module tb_fdivider_prog;
    import fdivider_prog_pkg::*;

    logic clk_in;
    logic reset;
    int unsigned edge_n = 0;

    fdivider_prog_if #(.WIDTH(8)) bus ();

    fdivider_prog #(.WIDTH(8), .DEFAULT_DIV(100)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned e;
        int          cnt;
        bit          clk;
        bit          tk;
        int          div;
        bit          err;
    } snap_t;

    snap_t       snap_q[$];
    int unsigned tick_q[$];
    int unsigned err_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    endtask

    task automatic push_snap(input int unsigned e, input int cnt, input bit clk,
                             input bit tk, input int div, input bit err);
        snap_t s;
        s.e = e; s.cnt = cnt; s.clk = clk; s.tk = tk; s.div = div; s.err = err;
        snap_q.push_back(s);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_in) begin
        if (edge_n >= 1) begin
            while (snap_q.size() > 0 && snap_q[0].e <= edge_n) begin
                snap_t s;
                s = snap_q.pop_front();
                if (s.e < edge_n) begin
                    fail_now("snap_stale", int'(edge_n), int'(s.e));
                end else begin
                    chk("snap_count",      int'(bus.count),      s.cnt);
                    chk("snap_clk_out",    int'(bus.clk_out),    int'(s.clk));
                    chk("snap_tick",       int'(bus.tick),       int'(s.tk));
                    chk("snap_div_active", int'(bus.div_active), s.div);
                    chk("snap_load_err",   int'(bus.load_err),   int'(s.err));
                end
            end

            if (bus.tick) begin
                if (tick_q.size() == 0) fail_now("tick_unexpected", int'(edge_n), -1);
                else chk("tick_edge", int'(edge_n), int'(tick_q.pop_front()));
            end else if (tick_q.size() > 0 && tick_q[0] <= edge_n) begin
                fail_now("tick_missing", int'(edge_n), int'(tick_q.pop_front()));
            end

            if (bus.load_err) begin
                if (err_q.size() == 0) fail_now("load_err_unexpected", int'(edge_n), -1);
                else chk("load_err_edge", int'(edge_n), int'(err_q.pop_front()));
            end else if (err_q.size() > 0 && err_q[0] <= edge_n) begin
                fail_now("load_err_missing", int'(edge_n), int'(err_q.pop_front()));
            end

            chk("inv_clk_out", int'(bus.clk_out),
                int'(32'(bus.count) >= (32'(bus.div_active) - high_phase(32'(bus.div_active)))));
            chk("inv_count_lt_n", int'(bus.count < bus.div_active), 1);
        end
    end

    // Stimulus
    initial begin
        int unsigned b;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.restart   = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;

        // 1: default N=100
        repeat (3) @(negedge clk_in);
        b = edge_n;
        push_snap(b + 1, 0, 0, 0, 100, 0);
        @(negedge clk_in);
        reset = 1'b0;
        bus.enable = 1'b1;
        b = edge_n;
        for (int k = 1; k <= 4; k++) tick_q.push_back(b + 100 * k);
        push_snap(b + 49,  49, 0, 0, 100, 0);
        push_snap(b + 50,  50, 1, 0, 100, 0);
        push_snap(b + 99,  99, 1, 0, 100, 0);
        push_snap(b + 100, 0,  0, 1, 100, 0);
        push_snap(b + 400, 0,  0, 1, 100, 0);
        repeat (400) @(negedge clk_in);

        // 2: N=7 loaded while frozen
        b = edge_n;
        bus.enable = 1'b0;
        bus.div_load = 1'b1;
        bus.div_value = 8'd7;
        push_snap(b + 1, 0, 0, 0, 7, 0);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        bus.enable = 1'b1;
        b = edge_n;
        push_snap(b + 1, 1, 0, 0, 7, 0);
        push_snap(b + 3, 3, 0, 0, 7, 0);
        push_snap(b + 4, 4, 1, 0, 7, 0);
        push_snap(b + 6, 6, 1, 0, 7, 0);
        push_snap(b + 7, 0, 0, 1, 7, 0);
        for (int k = 1; k <= 3; k++) tick_q.push_back(b + 7 * k);
        repeat (21) @(negedge clk_in);

        // 3: change 10 -> 4 mid-period, takes effect at wrap
        b = edge_n;
        bus.enable = 1'b0;
        bus.div_load = 1'b1;
        bus.div_value = 8'd10;
        push_snap(b + 1, 0, 0, 0, 10, 0);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        bus.enable = 1'b1;
        b = edge_n;
        repeat (3) @(negedge clk_in);
        bus.div_load = 1'b1;
        bus.div_value = 8'd4;
        push_snap(b + 4,  4, 0, 0, 10, 0);
        push_snap(b + 5,  5, 1, 0, 10, 0);
        push_snap(b + 9,  9, 1, 0, 10, 0);
        push_snap(b + 10, 0, 0, 1, 4,  0);
        push_snap(b + 12, 2, 1, 0, 4,  0);
        push_snap(b + 13, 3, 1, 0, 4,  0);
        push_snap(b + 14, 0, 0, 1, 4,  0);
        tick_q.push_back(b + 10);
        tick_q.push_back(b + 14);
        tick_q.push_back(b + 18);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        repeat (14) @(negedge clk_in);

        // 4: illegal divisors 1 and 0
        b = edge_n;
        bus.div_load = 1'b1;
        bus.div_value = 8'd1;
        err_q.push_back(b + 1);
        push_snap(b + 1, 1, 0, 0, 4, 1);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        @(negedge clk_in);
        bus.div_load = 1'b1;
        bus.div_value = 8'd0;
        err_q.push_back(b + 3);
        push_snap(b + 3, 3, 1, 0, 4, 1);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        push_snap(b + 4, 0, 0, 1, 4, 0);
        tick_q.push_back(b + 4);
        tick_q.push_back(b + 8);
        repeat (5) @(negedge clk_in);

        // 5: restart with simultaneous load, then freeze and resume
        b = edge_n;
        bus.enable = 1'b0;
        bus.div_load = 1'b1;
        bus.div_value = 8'd10;
        push_snap(b + 1, 0, 0, 0, 10, 0);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        bus.enable = 1'b1;
        b = edge_n;
        repeat (6) @(negedge clk_in);
        bus.restart = 1'b1;
        bus.div_load = 1'b1;
        bus.div_value = 8'd5;
        push_snap(b + 7, 0, 0, 0, 5, 0);
        @(negedge clk_in);
        bus.restart = 1'b0;
        bus.div_load = 1'b0;
        bus.enable = 1'b0;
        push_snap(b + 8,  0, 0, 0, 5, 0);
        push_snap(b + 15, 0, 0, 0, 5, 0);
        repeat (8) @(negedge clk_in);
        bus.enable = 1'b1;
        push_snap(b + 18, 3, 1, 0, 5, 0);
        push_snap(b + 19, 4, 1, 0, 5, 0);
        push_snap(b + 20, 0, 0, 1, 5, 0);
        tick_q.push_back(b + 20);
        repeat (5) @(negedge clk_in);

        // 6: reset mid-period discards a pending divisor
        b = edge_n;
        bus.enable = 1'b0;
        bus.div_load = 1'b1;
        bus.div_value = 8'd100;
        push_snap(b + 1, 0, 0, 0, 100, 0);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        bus.enable = 1'b1;
        b = edge_n;
        repeat (30) @(negedge clk_in);
        bus.div_load = 1'b1;
        bus.div_value = 8'd20;
        push_snap(b + 31, 31, 0, 0, 100, 0);
        @(negedge clk_in);
        bus.div_load = 1'b0;
        repeat (24) @(negedge clk_in);
        reset = 1'b1;
        push_snap(b + 56, 0, 0, 0, 100, 0);
        @(negedge clk_in);
        reset = 1'b0;
        b = edge_n;
        push_snap(b + 50,  50, 1, 0, 100, 0);
        push_snap(b + 100, 0,  0, 1, 100, 0);
        push_snap(b + 101, 1,  0, 0, 100, 0);
        push_snap(b + 120, 20, 0, 0, 100, 0);
        tick_q.push_back(b + 100);
        repeat (122) @(negedge clk_in);

        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            fail_now("snap_never_checked", int'(edge_n), int'(s.e));
        end
        while (tick_q.size() > 0) fail_now("tick_never_seen", int'(edge_n), int'(tick_q.pop_front()));
        while (err_q.size() > 0) fail_now("load_err_never_seen", int'(edge_n), int'(err_q.pop_front()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
